multicycle_control: RTL

//  Multi-cycle main control FSM for the MIPS-subset CPU; successor to the single-cycle opcode decoder.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/opcode_class.sv | 27 ++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// opcodes, FSM state codes, datapath select codes and instruction classes.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_EXEC_R = 4'd3;
   localparam logic [3:0] S_WB_R   = 4'd4;
   localparam logic [3:0] S_EXEC_I = 4'd5;
   localparam logic [3:0] S_WB_I   = 4'd6;
   localparam logic [3:0] S_MEMADR = 4'd7;
   localparam logic [3:0] S_MEMRD  = 4'd8;
   localparam logic [3:0] S_WB_MEM = 4'd9;
   localparam logic [3:0] S_MEMWR  = 4'd10;
   localparam logic [3:0] S_BRANCH = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   typedef enum logic [2:0] {
      CLS_R   = 3'd0,
      CLS_I   = 3'd1,
      CLS_LW  = 3'd2,
      CLS_SW  = 3'd3,
      CLS_BEQ = 3'd4,
      CLS_J   = 3'd5
   } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: maps the IR opcode to an instruction
// class and flags opcodes the control FSM does not implement.
module opcode_class
   import ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] op,
   output op_class_t       op_class,
   output logic            legal
);

   always_comb begin
      op_class = CLS_R;
      legal    = 1'b1;
      case (op)
         OP_W'(OP_RTYPE): op_class = CLS_R;
         OP_W'(OP_ADDI):  op_class = CLS_I;
         OP_W'(OP_LW):    op_class = CLS_LW;
         OP_W'(OP_SW):    op_class = CLS_SW;
         OP_W'(OP_BEQ):   op_class = CLS_BEQ;
         OP_W'(OP_J):     op_class = CLS_J;
         default:         legal    = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, handshakes with memory and counts retired instructions.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 2,
   parameter int CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [OP_W-1:0]    Op_i,
   input  logic               mem_ack_i,
   output logic               mem_req_o,
   output logic               MemRead_o,
   output logic               MemWrite_o,
   output logic               IorD_o,
   output logic               IRWrite_o,
   output logic               PCWrite_o,
   output logic               PCWriteCond_o,
   output logic [1:0]         PCSource_o,
   output logic               ALUSrcA_o,
   output logic [1:0]         ALUSrcB_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic               RegDst_o,
   output logic               MemtoReg_o,
   output logic               RegWrite_o,
   output logic               illegal_o,
   output logic [CNT_W-1:0]   instr_cnt_o
);

   logic [3:0] state, state_nxt;
   op_class_t  cls_q, dec_cls;
   logic       dec_legal;
   logic       retire;

   opcode_class #(.OP_W(OP_W)) u_opcode_class (
      .op       (Op_i),
      .op_class (dec_cls),
      .legal    (dec_legal)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH:  if (mem_ack_i) state_nxt = S_DECODE;
         S_DECODE: begin
            if (!dec_legal) state_nxt = S_FETCH;
            else begin
               case (dec_cls)
                  CLS_R:         state_nxt = S_EXEC_R;
                  CLS_I:         state_nxt = S_EXEC_I;
                  CLS_LW, CLS_SW: state_nxt = S_MEMADR;
                  CLS_BEQ:       state_nxt = S_BRANCH;
                  CLS_J:         state_nxt = S_JUMP;
                  default:       state_nxt = S_FETCH;
               endcase
            end
         end
         S_EXEC_R: state_nxt = S_WB_R;
         S_EXEC_I: state_nxt = S_WB_I;
         // The load/store choice comes from the class latched at decode, not Op_i.
         S_MEMADR: state_nxt = (cls_q == CLS_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ack_i) state_nxt = S_WB_MEM;
         S_MEMWR:  if (mem_ack_i) state_nxt = S_FETCH;
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      retire = 1'b0;
      case (state)
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
         S_MEMWR:  retire = mem_ack_i;
         default:  retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         cls_q       <= CLS_R;
         instr_cnt_o <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) cls_q <= dec_cls;
         if (retire) instr_cnt_o <= instr_cnt_o + CNT_W'(1);
      end
   end

   // Moore decode; only the fetch-side IR/PC loads look at the ack.
   always_comb begin
      mem_req_o     = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IorD_o        = 1'b0;
      IRWrite_o     = 1'b0;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      PCSource_o    = PCSRC_ALU;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = SRCB_RT;
      ALUOp_o       = '0;
      RegDst_o      = 1'b0;
      MemtoReg_o    = 1'b0;
      RegWrite_o    = 1'b0;
      illegal_o     = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req_o = 1'b1;
            MemRead_o = 1'b1;
            ALUSrcB_o = SRCB_FOUR;
            ALUOp_o   = ALUOP_W'(ALUOP_ADD);
            IRWrite_o = mem_ack_i;
            PCWrite_o = mem_ack_i;
         end
         S_DECODE: begin
            ALUSrcB_o = SRCB_IMM_SH;
            ALUOp_o   = ALUOP_W'(ALUOP_ADD);
            illegal_o = !dec_legal;
         end
         S_EXEC_R: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = SRCB_RT;
            ALUOp_o   = ALUOP_W'(ALUOP_FUNCT);
         end
         S_WB_R: begin
            RegDst_o   = 1'b1;
            RegWrite_o = 1'b1;
         end
         S_EXEC_I, S_MEMADR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = SRCB_IMM;
            ALUOp_o   = ALUOP_W'(ALUOP_ADD);
         end
         S_WB_I:   RegWrite_o = 1'b1;
         S_MEMRD: begin
            mem_req_o = 1'b1;
            MemRead_o = 1'b1;
            IorD_o    = 1'b1;
         end
         S_WB_MEM: begin
            MemtoReg_o = 1'b1;
            RegWrite_o = 1'b1;
         end
         S_MEMWR: begin
            mem_req_o  = 1'b1;
            MemWrite_o = 1'b1;
            IorD_o     = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA_o     = 1'b1;
            ALUSrcB_o     = SRCB_RT;
            ALUOp_o       = ALUOP_W'(ALUOP_SUB);
            PCWriteCond_o = 1'b1;
            PCSource_o    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite_o  = 1'b1;
            PCSource_o = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

endmodule
